// File: rtl/sdram_bist_gen.sv
// sdram_bist_gen: parametrised SDRAM write/readback self-test generator.
// Writes NUM_WORDS pattern words from BASE_ADDR with ADDR_STRIDE spacing,
// reads them back in order and compares the returned data.
// Reports pass/fail, the mismatch count and the first failing address.
// Optional read-return watchdog: define SDRAM_BIST_TIMEOUT_EN.
module sdram_bist_gen #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 25,
   parameter int NUM_WORDS      = 10,
   parameter int BASE_ADDR      = 0,
   parameter int ADDR_STRIDE    = 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                               Clock,
   input  logic                               Rst,
   input  logic                               Start,
   input  logic [1:0]                         Mode,
   output logic                               WrRequest,
   input  logic                               WrReady,
   output logic [DATA_WIDTH-1:0]              WriteData,
   output logic [ADDR_WIDTH-1:0]              WriteAddress,
   output logic                               RdRequest,
   input  logic                               RdReady,
   output logic [ADDR_WIDTH-1:0]              ReadAddress,
   input  logic [DATA_WIDTH-1:0]              ReadData,
   input  logic                               ReadDataValid,
   output logic                               Busy,
   output logic                               Done,
   output logic                               Pass,
   output logic [$clog2(NUM_WORDS+1)-1:0]     ErrCount,
   output logic [ADDR_WIDTH-1:0]              FirstErrAddr,
   output logic                               Timeout
);

   localparam int IW = $clog2(NUM_WORDS + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WRITE   = 3'd1,
      ST_READ    = 3'd2,
      ST_WAIT_RD = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic [IW-1:0]         wr_idx_q, wr_idx_d;
   logic [IW-1:0]         rd_idx_q, rd_idx_d;
   logic [IW-1:0]         ret_idx_q, ret_idx_d;
   logic [IW-1:0]         err_cnt_q, err_cnt_d;
   logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;
   logic                  ret_fire;

`ifdef SDRAM_BIST_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WDW-1:0]        wd_q, wd_d;
   logic                  timeout_q, timeout_d;
`endif

   // Test pattern for word idx under the given mode.
   function automatic logic [DATA_WIDTH-1:0] pattern_f(input logic [1:0] m, input logic [IW-1:0] idx);
      logic [DATA_WIDTH-1:0] p;
      p = '0;
      case (m)
         2'd0: p = DATA_WIDTH'(idx);
         2'd1: p = ~DATA_WIDTH'(idx);
         2'd2: p = DATA_WIDTH'(1'b1) << (32'(idx) % DATA_WIDTH);
         2'd3: begin
            for (int k = 0; k < DATA_WIDTH; k++) begin
               p[k] = ((k % 2) == 0) ? ~idx[0] : idx[0];
            end
         end
         default: p = '0;
      endcase
      return p;
   endfunction

   // Memory address for word idx; wraps modulo 2^ADDR_WIDTH.
   function automatic logic [ADDR_WIDTH-1:0] addr_f(input logic [IW-1:0] idx);
      return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx) * ADDR_WIDTH'(ADDR_STRIDE);
   endfunction

   // Next-state logic: sequencing, compare path and optional watchdog.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      ret_idx_d   = ret_idx_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
`ifdef SDRAM_BIST_TIMEOUT_EN
      wd_d        = wd_q;
      timeout_d   = timeout_q;
`endif

      // Returns are only meaningful while reading and before all words came back.
      ret_fire = ((state_q == ST_READ) || (state_q == ST_WAIT_RD)) && ReadDataValid &&
                 (ret_idx_q != IW'(NUM_WORDS));
      if (ret_fire) begin
         ret_idx_d = ret_idx_q + IW'(1);
         if (ReadData != pattern_f(mode_q, ret_idx_q)) begin
            err_cnt_d = err_cnt_q + IW'(1);
            if (err_cnt_q == IW'(0)) begin
               first_err_d = addr_f(ret_idx_q);
            end else begin
               first_err_d = first_err_q;
            end
         end else begin
            err_cnt_d = err_cnt_q;
         end
      end else begin
         ret_idx_d = ret_idx_q;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (Start) begin
               mode_d      = Mode;
               wr_idx_d    = '0;
               rd_idx_d    = '0;
               ret_idx_d   = '0;
               err_cnt_d   = '0;
               first_err_d = '0;
`ifdef SDRAM_BIST_TIMEOUT_EN
               wd_d        = '0;
               timeout_d   = 1'b0;
`endif
               state_d     = ST_WRITE;
            end else begin
               state_d = state_q;
            end
         end
         ST_WRITE: begin
            if (WrReady) begin
               wr_idx_d = wr_idx_q + IW'(1);
               if (wr_idx_q == IW'(NUM_WORDS - 1)) begin
                  state_d = ST_READ;
               end else begin
                  state_d = ST_WRITE;
               end
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_READ: begin
            if (RdReady) begin
               rd_idx_d = rd_idx_q + IW'(1);
               if (rd_idx_q == IW'(NUM_WORDS - 1)) begin
                  state_d = (ret_idx_d == IW'(NUM_WORDS)) ? ST_DONE : ST_WAIT_RD;
               end else begin
                  state_d = ST_READ;
               end
            end else begin
               state_d = ST_READ;
            end
         end
         ST_WAIT_RD: begin
            if (ret_idx_d == IW'(NUM_WORDS)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT_RD;
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef SDRAM_BIST_TIMEOUT_EN
      // Watchdog: counts while returns are outstanding, cleared by any return.
      if ((state_q == ST_READ) || (state_q == ST_WAIT_RD)) begin
         if (ReadDataValid) begin
            wd_d = '0;
         end else if (rd_idx_q > ret_idx_q) begin
            wd_d = wd_q + WDW'(1);
         end else begin
            wd_d = wd_q;
         end
         if (wd_d == WDW'(TIMEOUT_CYCLES)) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
         end else begin
            timeout_d = timeout_q;
         end
      end else begin
         wd_d = wd_d;
      end
`endif
   end

   // State and counter registers.
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         state_q     <= ST_IDLE;
         mode_q      <= 2'd0;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         ret_idx_q   <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
`ifdef SDRAM_BIST_TIMEOUT_EN
         wd_q        <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         ret_idx_q   <= ret_idx_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
`ifdef SDRAM_BIST_TIMEOUT_EN
         wd_q        <= wd_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

`ifdef SDRAM_BIST_TIMEOUT_EN
   assign Timeout = timeout_q;
`else
   assign Timeout = 1'b0;
`endif

   // Outputs decoded from state and counters only (never from Ready inputs).
   always_comb begin
      WrRequest    = (state_q == ST_WRITE);
      RdRequest    = (state_q == ST_READ);
      Busy         = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_WAIT_RD);
      Done         = (state_q == ST_DONE);
      Pass         = Done && (err_cnt_q == IW'(0)) && !Timeout;
      ErrCount     = err_cnt_q;
      FirstErrAddr = first_err_q;
      if (state_q == ST_WRITE) begin
         WriteData    = pattern_f(mode_q, wr_idx_q);
         WriteAddress = addr_f(wr_idx_q);
      end else begin
         WriteData    = '0;
         WriteAddress = '0;
      end
      if (state_q == ST_READ) begin
         ReadAddress = addr_f(rd_idx_q);
      end else begin
         ReadAddress = '0;
      end
   end

endmodule

// File: tb/tb_sdram_bist_gen.sv
// Self-checking bench for sdram_bist_gen: randomized ready/latency/corruption
// against a behavioural memory and pattern model.
module tb_sdram_bist_gen;

   localparam int DW     = 16;
   localparam int AW     = 25;
   localparam int NW     = 20;
   localparam int BASE   = 32'h100;
   localparam int STRIDE = 2;
   localparam int TO     = 16;
   localparam int CW     = $clog2(NW + 1);

   logic          Clock = 1'b0;
   logic          Rst, Start, WrReady, RdReady, ReadDataValid;
   logic [1:0]    Mode;
   logic [DW-1:0] ReadData;
   logic          WrRequest, RdRequest, Busy, Done, Pass, Timeout;
   logic [DW-1:0] WriteData;
   logic [AW-1:0] WriteAddress, ReadAddress, FirstErrAddr;
   logic [CW-1:0] ErrCount;

   sdram_bist_gen #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW), .BASE_ADDR(BASE),
      .ADDR_STRIDE(STRIDE), .TIMEOUT_CYCLES(TO)
   ) dut (
      .Clock(Clock), .Rst(Rst), .Start(Start), .Mode(Mode),
      .WrRequest(WrRequest), .WrReady(WrReady), .WriteData(WriteData), .WriteAddress(WriteAddress),
      .RdRequest(RdRequest), .RdReady(RdReady), .ReadAddress(ReadAddress),
      .ReadData(ReadData), .ReadDataValid(ReadDataValid),
      .Busy(Busy), .Done(Done), .Pass(Pass), .ErrCount(ErrCount),
      .FirstErrAddr(FirstErrAddr), .Timeout(Timeout)
   );

   always #5 Clock = ~Clock;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] mem [int];
   int            rq_due[$];
   int            rq_addr[$];
   logic [DW-1:0] cmask [NW];
   int            cyc, wr_cnt, rd_cnt, ret_cnt, exp_err, cur_mode;
   logic [AW-1:0] exp_first;
   int            wr_pol, rd_pol, lat_min, lat_max, max_ret, last_ret_edge;
   int            wr_first, wr_last;
   bit            start_in_write, prev_stall;
   logic [DW-1:0] prev_wd;
   logic [AW-1:0] prev_wa;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pattern rules written straight from the mode definitions.
   function automatic logic [DW-1:0] exp_pat(input int m, input int i);
      case (m)
         0:       return 16'(i);
         1:       return ~16'(i);
         2:       return 16'(1) << (i % DW);
         default: return ((i % 2) == 0) ? 16'h5555 : 16'hAAAA;
      endcase
   endfunction

   function automatic logic [AW-1:0] exp_addr(input int i);
      return AW'(BASE + i * STRIDE);
   endfunction

   // One clock cycle: drive inputs, observe handshakes, advance past the edge.
   task automatic cycle(input logic st);
      int a;
      int due;
      Start = st;
      if (start_in_write && WrRequest && wr_cnt == 3) Start = 1'b1;
      case (wr_pol)
         0:       WrReady = 1'b1;
         1:       WrReady = ((cyc % 3) == 0);
         default: WrReady = 1'($urandom_range(0, 1));
      endcase
      RdReady       = (rd_pol == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ReadDataValid = 1'b0;
      ReadData      = 16'($urandom);
      if (rq_due.size() > 0 && rq_due[0] <= cyc && ret_cnt < max_ret && ret_cnt < NW) begin
         a = rq_addr.pop_front();
         void'(rq_due.pop_front());
         ReadDataValid = 1'b1;
         ReadData = (mem.exists(a) ? mem[a] : 16'h0) ^ cmask[ret_cnt];
         if (ReadData !== exp_pat(cur_mode, ret_cnt)) begin
            if (exp_err == 0) exp_first = exp_addr(ret_cnt);
            exp_err++;
         end
         ret_cnt++;
         last_ret_edge = cyc + 1;
      end
      #1;
      if (prev_stall && WrRequest) begin
         check("wr_hold_data", WriteData, prev_wd);
         check("wr_hold_addr", WriteAddress, prev_wa);
      end
      prev_stall = WrRequest && !WrReady;
      prev_wd    = WriteData;
      prev_wa    = WriteAddress;
      if (WrRequest && WrReady) begin
         check("wr_addr", WriteAddress, exp_addr(wr_cnt));
         check("wr_data", WriteData, exp_pat(cur_mode, wr_cnt));
         mem[int'(WriteAddress)] = WriteData;
         if (wr_cnt == 0) wr_first = cyc;
         wr_last = cyc;
         wr_cnt++;
      end
      if (RdRequest && RdReady) begin
         check("rd_addr", ReadAddress, exp_addr(rd_cnt));
         due = cyc + $urandom_range(lat_min, lat_max);
         if (rq_due.size() > 0 && due <= rq_due[$]) due = rq_due[$] + 1;
         rq_due.push_back(due);
         rq_addr.push_back(int'(ReadAddress));
         rd_cnt++;
      end
      @(posedge Clock);
      #1;
      cyc++;
   endtask

   task automatic clear_model();
      rq_due.delete();
      rq_addr.delete();
      mem.delete();
      wr_cnt = 0; rd_cnt = 0; ret_cnt = 0; exp_err = 0; exp_first = '0;
      prev_stall = 1'b0;
   endtask

   task automatic run_pass(input int m, input string tag, input bit expect_to, input bit consec);
      int n;
      clear_model();
      cur_mode = m;
      Mode = 2'(m);
      cycle(1'b1);
      Mode = ~2'(m);
      check({tag, "_wrreq_first"}, WrRequest, 1'b1);
      check({tag, "_busy"}, Busy, 1'b1);
      n = 0;
      while (Done !== 1'b1 && n < 3000) begin
         cycle(1'b0);
         n++;
      end
      check({tag, "_done"}, Done, 1'b1);
      check({tag, "_writes"}, wr_cnt, NW);
      check({tag, "_reads"}, rd_cnt, NW);
      check({tag, "_returns"}, ret_cnt, expect_to ? 6 : NW);
      check({tag, "_errcount"}, ErrCount, exp_err);
      check({tag, "_firsterr"}, FirstErrAddr, exp_first);
      check({tag, "_pass"}, Pass, (exp_err == 0) && !expect_to);
      check({tag, "_timeout"}, Timeout, expect_to);
      check({tag, "_notbusy"}, Busy, 1'b0);
      if (consec) check({tag, "_consecutive"}, wr_last - wr_first, NW - 1);
      if (expect_to) check({tag, "_to_delay"}, cyc - last_ret_edge, TO);
      start_in_write = 1'b0;
      repeat (3) cycle(1'b0);
      check({tag, "_done_hold"}, Done, 1'b1);
      check({tag, "_err_hold"}, ErrCount, exp_err);
      if (Done !== 1'b1) begin
         Rst = 1'b1;
         @(posedge Clock); #1;
         Rst = 1'b0;
         cyc++;
      end
      clear_model();
   endtask

   initial begin
      int n;
      Rst = 1'b1; Start = 1'b0; Mode = 2'd0; WrReady = 1'b0; RdReady = 1'b0;
      ReadData = '0; ReadDataValid = 1'b0;
      cyc = 0; wr_pol = 0; rd_pol = 0; lat_min = 3; lat_max = 3; max_ret = NW;
      start_in_write = 1'b0; last_ret_edge = 0; wr_first = 0; wr_last = 0;
      for (int i = 0; i < NW; i++) cmask[i] = '0;
      clear_model();
      repeat (2) @(posedge Clock);
      #1;
      check("rst_outputs", {WrRequest, RdRequest, Busy, Done, Pass, Timeout}, 6'b0);
      check("rst_err", {ErrCount, FirstErrAddr, WriteData, WriteAddress, ReadAddress}, '0);
      Rst = 1'b0;
      cycle(1'b0);
      check("idle_no_start", {Busy, Done}, 2'b0);

      // Clean mode-0 pass, always ready, fixed 3-cycle return latency.
      run_pass(0, "m0_clean", 1'b0, 1'b1);

      // Walking one across the DATA_WIDTH wrap, random backpressure.
      wr_pol = 2; rd_pol = 1; lat_min = 1; lat_max = 4;
      run_pass(2, "m2_walk", 1'b0, 1'b0);
      check("walk16_model", exp_pat(2, 16), 16'h0001);

      // Checkerboard.
      run_pass(3, "m3_chk", 1'b0, 1'b0);

      // 1-of-3 write ready, Start pulsed during WRITE must be ignored.
      wr_pol = 1; start_in_write = 1'b1;
      run_pass(1, "m1_stall", 1'b0, 1'b0);

      // Corrupted words 4 (bit 0) and 7.
      wr_pol = 2;
      cmask[4] = 16'h0001;
      cmask[7] = 16'($urandom_range(1, 65535));
      run_pass(int'($urandom_range(0, 3)), "corrupt", 1'b0, 1'b0);
      check("corrupt_cnt_const", ErrCount, 2);
      check("corrupt_addr_const", FirstErrAddr, 25'h108);
      for (int i = 0; i < NW; i++) cmask[i] = '0;

      // Random passes with random corruption.
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < NW; i++)
            cmask[i] = ($urandom_range(0, 4) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
         run_pass(int'($urandom_range(0, 3)), "random", 1'b0, 1'b0);
      end
      for (int i = 0; i < NW; i++) cmask[i] = '0;

      // Asynchronous reset in the middle of the read phase.
      wr_pol = 0; rd_pol = 0; lat_min = 3; lat_max = 3;
      clear_model();
      cur_mode = 0; Mode = 2'd0;
      cycle(1'b1);
      n = 0;
      while (rd_cnt < 5 && n < 500) begin
         cycle(1'b0);
         n++;
      end
      check("midread_reached", rd_cnt, 5);
      Rst = 1'b1;
      #1;
      check("midread_rst_ctl", {WrRequest, RdRequest, Busy, Done, Pass, Timeout}, 6'b0);
      check("midread_rst_data", {ErrCount, FirstErrAddr, WriteData, WriteAddress, ReadAddress}, '0);
      @(posedge Clock); #1;
      cyc++;
      Rst = 1'b0;
      clear_model();
      run_pass(0, "after_rst", 1'b0, 1'b1);

`ifdef SDRAM_BIST_TIMEOUT_EN
      // Returns stop after six words; the watchdog must end the pass.
      max_ret = 6;
      run_pass(0, "watchdog", 1'b1, 1'b0);
      max_ret = NW;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
